muldiv_unit: RTL and testbench

Sequential multiply/divide unit for the EX stage of the MIPS core. It sits beside the ALU on the same operand buses, `A` and `B`, and uses the same `ALU_Control` op encoding. It takes over `MUL`/`MULU`/`DIV`/`DIVU` as 32-iteration shift-add / restoring-divide operations, owns the architectural Hi/Lo registers, and supplies the values for `MFHI`/`MFLO` (for which the ALU returns 0). It stalls the pipeline through `busy` while an operation is in flight.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 41 ++++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
//------------------------------------------------------------------------------
// muldiv_unit_pkg : op codes, FSM states and op-class helpers for muldiv_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_unit_pkg;

  localparam int c_WIDTH = 32;

  // ALU_Control codes handled by the multiply/divide unit
  localparam logic [4:0] c_OP_MUL  = 5'h18;
  localparam logic [4:0] c_OP_MULU = 5'h19;
  localparam logic [4:0] c_OP_DIV  = 5'h1A;
  localparam logic [4:0] c_OP_DIVU = 5'h1B;
  localparam logic [4:0] c_OP_MTHI = 5'h11;
  localparam logic [4:0] c_OP_MTLO = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_long_op(input logic [4:0] op);
    return (op == c_OP_MUL) || (op == c_OP_MULU) ||
           (op == c_OP_DIV) || (op == c_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == c_OP_DIV) || (op == c_OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
//------------------------------------------------------------------------------
// muldiv_iter : one combinational shift-add (multiply) or restoring-subtract
//               (divide) step on the {acc, low} working register pair.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH:0]   opnd,
  output logic [WIDTH:0]   acc_nx,
  output logic [WIDTH-1:0] low_nx
);

  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  always_comb begin
    w_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    w_shift = {acc, low[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, opnd});
    // When the trial succeeds the true difference is below opnd, so W+1 bits suffice
    w_diff  = w_shift[WIDTH:0] - opnd;
    if (is_div) begin
      acc_nx = w_ge ? w_diff : w_shift[WIDTH:0];
      low_nx = {low[WIDTH-2:0], w_ge};
    end else begin
      acc_nx = w_sum[WIDTH+1:1];
      low_nx = {w_sum[0], low[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit : sequential MUL/MULU/DIV/DIVU engine owning the HI/LO registers,
//               with single-cycle MTHI/MTLO writes and a busy stall output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int c_ITER  = WIDTH;
  localparam int c_CNT_W = 6;

  md_state_t          r_state, w_state_nx;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_zero;
  logic [WIDTH:0]     r_acc, r_opnd;
  logic [WIDTH-1:0]   r_low;
  logic               r_busy, r_done, r_dbz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_long, w_mt, w_div, w_signed, w_accept, w_b_zero;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH:0]     w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_acc_nx;
  logic [WIDTH-1:0]   w_low_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;

  assign w_long   = is_long_op(op);
  assign w_div    = is_div_op(op);
  assign w_mt     = (op == c_OP_MTHI) || (op == c_OP_MTLO);
  assign w_signed = (op == c_OP_MUL) || (op == c_OP_DIV);
  assign w_accept = (r_state == IDLE) && start && !flush && (w_long || w_mt);
  assign w_b_zero = (B == '0);
  assign w_a_neg  = w_signed & A[WIDTH-1];
  assign w_b_neg  = w_signed & B[WIDTH-1];
  // One extra bit so the magnitude of the most negative value is representable
  assign w_a_mag  = w_a_neg ? ({1'b0, ~A} + (WIDTH+1)'(1)) : {1'b0, A};
  assign w_b_mag  = w_b_neg ? ({1'b0, ~B} + (WIDTH+1)'(1)) : {1'b0, B};

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (r_is_div),
    .acc    (r_acc),
    .low    (r_low),
    .opnd   (r_opnd),
    .acc_nx (w_acc_nx),
    .low_nx (w_low_nx)
  );

  always_comb begin
    w_prod = {r_acc[WIDTH-1:0], r_low};
    if (r_neg_q) w_prod = -w_prod;
    w_quo = r_neg_q ? -r_low : r_low;
    w_rem = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end else begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (w_accept && w_long) w_state_nx = (w_div && w_b_zero) ? FIX : RUN;
      RUN:  if (r_cnt == c_CNT_W'(c_ITER - 1)) w_state_nx = FIX;
      FIX:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (flush) w_state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_low    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nx != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dbz <= 1'b0;
            if (op == c_OP_MTHI) r_hi <= A;
            if (op == c_OP_MTLO) r_lo <= A;
            if (w_mt) r_done <= 1'b1;
            if (w_long) begin
              r_cnt    <= '0;
              r_is_div <= w_div;
              r_zero   <= w_div & w_b_zero;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_acc    <= '0;
              if (w_div) begin
                // A zero divisor leaves {acc, low} at 0 so FIX writes zeros
                r_low  <= w_b_zero ? '0 : w_a_mag[WIDTH-1:0];
                r_opnd <= w_b_mag;
              end else begin
                r_low  <= w_b_mag[WIDTH-1:0];
                r_opnd <= w_a_mag;
              end
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_nx;
          r_low <= w_low_nx;
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        FIX: begin
          if (!flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_dbz  <= r_zero;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign Hi          = r_hi;
  assign Lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// tb_muldiv_unit : directed plus randomized checks of muldiv_unit against an
//                  arithmetic reference model of HI/LO, latency and busy time.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] Hi, Lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dbz = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Hi          (Hi),
    .Lo          (Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural result of one op plus its done latency and busy time
  task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int nbusy);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dbz = 1'b0;
    lat = 34;
    nbusy = 33;
    case (o)
      c_OP_MUL:  begin p = sa * sb; {m_hi, m_lo} = 64'(p); end
      c_OP_MULU: begin u = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = u; end
      c_OP_DIV, c_OP_DIVU: begin
        if (b == 32'd0) begin
          m_hi = '0; m_lo = '0; m_dbz = 1'b1; lat = 2; nbusy = 1;
        end else if (o == c_OP_DIV) begin
          m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      c_OP_MTHI: begin m_hi = a; lat = 1; nbusy = 0; end
      default:   begin m_lo = a; lat = 1; nbusy = 0; end
    endcase
  endtask

  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int k, nb, lat, exp_nb;
    logic seen;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    model(o, a, b, lat, exp_nb);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    k = 0; nb = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (k == 1) begin
        check("dbz_clear_at_accept", div_by_zero, 0);
        if (lat > 1) begin
          check("hi_held_in_flight", Hi, old_hi);
          check("lo_held_in_flight", Lo, old_lo);
        end
      end
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    check("done_latency", k, lat);
    check("busy_cycles", nb, exp_nb);
    check("hi", Hi, m_hi);
    check("lo", Lo, m_lo);
    check("div_by_zero", div_by_zero, m_dbz);
  endtask

  initial begin
    int lat, nb;
    logic any_done;
    logic [4:0] ops [6];
    ops = '{c_OP_MUL, c_OP_MULU, c_OP_DIV, c_OP_DIVU, c_OP_MTHI, c_OP_MTLO};

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op(c_OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(c_OP_MUL,  32'hFFFFFFFD, 32'd7);
    do_op(c_OP_MUL,  32'h80000000, 32'h80000000);
    do_op(c_OP_DIV,  32'hFFFFFFF9, 32'd2);
    do_op(c_OP_DIVU, 32'd7, 32'd2);
    do_op(c_OP_DIV,  32'h80000000, 32'hFFFFFFFF);
    do_op(c_OP_DIV,  32'd5, 32'd0);
    do_op(c_OP_DIVU, 32'd9, 32'd3);

    // MTHI and MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = c_OP_MTHI; A = 32'h12345678;
    @(posedge clk); #1;
    m_hi = 32'h12345678;
    check("mthi_done", done, 1);
    check("mthi_busy", busy, 0);
    check("mthi_hi", Hi, m_hi);
    op = c_OP_MTLO; A = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    m_lo = 32'h9ABCDEF0;
    check("mtlo_done", done, 1);
    check("mtlo_busy", busy, 0);
    check("mtlo_lo", Lo, m_lo);
    check("mtlo_hi_kept", Hi, m_hi);

    // Unsupported op code is ignored
    @(negedge clk);
    start = 1'b1; op = 5'h00; A = 32'h55555555;
    @(posedge clk); #1;
    start = 1'b0;
    check("badop_busy", busy, 0);
    check("badop_done", done, 0);
    check("badop_lo", Lo, m_lo);

    // Flush at iteration 10, with an ignored start during RUN
    do_op(c_OP_DIV, 32'd5, 32'd0);
    @(negedge clk);
    start = 1'b1; op = c_OP_DIV; A = 32'd100; B = 32'd7;
    m_dbz = 1'b0;
    any_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    any_done |= done;
    repeat (3) begin @(posedge clk); #1; any_done |= done; end
    start = 1'b1; op = c_OP_MTHI; A = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    any_done |= done;
    check("ignored_start_busy", busy, 1);
    check("ignored_start_hi", Hi, m_hi);
    repeat (4) begin @(posedge clk); #1; any_done |= done; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    repeat (40) begin @(posedge clk); #1; any_done |= done; end
    check("flush_no_done", any_done, 0);
    check("flush_hi", Hi, m_hi);
    check("flush_lo", Lo, m_lo);
    check("flush_dbz", div_by_zero, m_dbz);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] o;
      logic [31:0] a, b;
      o = ops[$urandom_range(0, 5)];
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op(o, a, b);
    end

    // Asynchronous reset in the middle of a multiply
    do_op(c_OP_MTHI, 32'h11111111, 32'd0);
    @(negedge clk);
    start = 1'b1; op = c_OP_MULU; A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hi", Hi, 0);
    check("async_rst_lo", Lo, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    do_op(c_OP_DIVU, 32'd9, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
